// File: rtl/opcode_sequencer_if.sv
// Controller-side bus of the opcode sequencer: PC control strobes in, fetched opcode and pc out.
interface opcode_sequencer_if #(
  parameter int AW = 4
);
  logic          IRWrite;
  logic          PCWrite;
  logic          PCWriteCond;
  logic [1:0]    PCSource;
  logic          zero;
  logic [AW-1:0] jump_target;
  logic [5:0]    opcode;
  logic [AW-1:0] pc;

  modport master (
    output IRWrite, PCWrite, PCWriteCond, PCSource, zero, jump_target,
    input  opcode, pc
  );

  modport slave (
    input  IRWrite, PCWrite, PCWriteCond, PCSource, zero, jump_target,
    output opcode, pc
  );
endinterface

// File: rtl/opcode_sequencer.sv
// Loadable 6-bit opcode store that answers the multicycle controller's fetch strobe
// and tracks a program counter driven by the controller's PC write controls.
module opcode_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic [AW-1:0]       load_addr,
  input  logic [5:0]          load_opcode,
  input  logic                start,
  opcode_sequencer_if.slave   ctrl,
  output logic                busy,
  output logic                done,
  output logic [15:0]         instr_count
);

  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [5:0] NOP_OP  = 6'b000000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [5:0]    prog [DEPTH];
  logic [AW-1:0] pc_q;
  logic [5:0]    opcode_q;
  logic          halt_pending;
  logic [5:0]    fetch_word;
  logic          pc_load;

  assign fetch_word = prog[pc_q];
  assign pc_load    = (ctrl.PCWrite && ctrl.PCSource == 2'b10) ||
                      (ctrl.PCWriteCond && ctrl.zero && ctrl.PCSource == 2'b01);

  assign ctrl.pc     = pc_q;
  assign ctrl.opcode = opcode_q;

  // A HALT fetch only arms halt_pending; the move to DONE happens one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc_q         <= '0;
      opcode_q     <= NOP_OP;
      instr_count  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      halt_pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        prog[i] <= NOP_OP;
      end
    end else begin
      if (state == IDLE && load_en) begin
        prog[load_addr] <= load_opcode;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pc_q         <= '0;
            opcode_q     <= NOP_OP;
            instr_count  <= '0;
            halt_pending <= 1'b0;
          end
        end
        RUN: begin
          if (halt_pending) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            halt_pending <= 1'b0;
          end else begin
            if (ctrl.IRWrite) begin
              if (fetch_word == HALT_OP) begin
                opcode_q     <= NOP_OP;
                halt_pending <= 1'b1;
              end else begin
                opcode_q <= fetch_word;
                pc_q     <= pc_q + 1'b1;
              end
              if (instr_count != 16'hFFFF) begin
                instr_count <= instr_count + 16'd1;
              end
            end
            // Jump/branch target wins over the implicit fetch increment.
            if (pc_load) begin
              pc_q <= ctrl.jump_target;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed test-plan scenarios plus a randomized run, all checked against a behavioural model.
module tb_opcode_sequencer;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [5:0]  load_opcode;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] instr_count;

  int checks = 0;
  int passed = 0;

  opcode_sequencer_if #(.AW(4)) bus ();

  opcode_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_opcode (load_opcode),
    .start       (start),
    .ctrl        (bus.slave),
    .busy        (busy),
    .done        (done),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: program array, counters and run/finished flags.
  logic [5:0] m_prog [16];
  int         m_pc;
  int         m_count;
  logic [5:0] m_op;
  bit         m_running;
  bit         m_finished;
  bit         m_halt_seen;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_prog[i] = 6'd0;
    m_pc = 0;
    m_count = 0;
    m_op = 6'd0;
    m_running = 0;
    m_finished = 0;
    m_halt_seen = 0;
  endtask

  task automatic model_step();
    int next_pc;
    if (!m_running && !m_finished && load_en) m_prog[load_addr] = load_opcode;
    if (!m_running && start) begin
      m_pc = 0;
      m_count = 0;
      m_op = 6'd0;
      m_running = 1;
      m_finished = 0;
      m_halt_seen = 0;
    end else if (m_running && m_halt_seen) begin
      m_running = 0;
      m_finished = 1;
      m_halt_seen = 0;
    end else if (m_running) begin
      next_pc = m_pc;
      if (bus.IRWrite) begin
        if (m_prog[m_pc] == 6'b111111) begin
          m_op = 6'd0;
          m_halt_seen = 1;
        end else begin
          m_op = m_prog[m_pc];
          next_pc = (m_pc + 1) % 16;
        end
        if (m_count < 65535) m_count = m_count + 1;
      end
      if ((bus.PCWrite && bus.PCSource == 2'd2) ||
          (bus.PCWriteCond && bus.zero && bus.PCSource == 2'd1))
        next_pc = int'(bus.jump_target);
      m_pc = next_pc;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".opcode"}, 32'(bus.opcode), 32'(m_op));
    check_output({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
    check_output({tag, ".busy"}, 32'(busy), 32'(m_running));
    check_output({tag, ".done"}, 32'(done), 32'(m_finished));
    check_output({tag, ".count"}, 32'(instr_count), 32'(m_count));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic irw, input logic pcw, input logic pcwc,
                                input logic [1:0] src, input logic z, input logic [3:0] tgt);
    bus.IRWrite = irw;
    bus.PCWrite = pcw;
    bus.PCWriteCond = pcwc;
    bus.PCSource = src;
    bus.zero = z;
    bus.jump_target = tgt;
  endtask

  task automatic idle_inputs();
    apply_stimulus(0, 0, 0, 2'd0, 0, 4'd0);
    load_en = 0;
    load_addr = 4'd0;
    load_opcode = 6'd0;
    start = 0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2 reset = 0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    #2 reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_slot(input logic [3:0] addr, input logic [5:0] op);
    load_en = 1;
    load_addr = addr;
    load_opcode = op;
    tick();
    load_en = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic fetch();
    apply_stimulus(1, 0, 0, 2'd0, 0, 4'd0);
    tick();
    apply_stimulus(0, 0, 0, 2'd0, 0, 4'd0);
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    do_reset("reset");

    // Basic program with fetches every 4 cycles
    load_slot(4'd0, 6'b010010);
    load_slot(4'd1, 6'b110010);
    load_slot(4'd2, 6'b111111);
    pulse_start();
    check_all("basic.start");
    fetch();
    check_output("basic.op1", 32'(bus.opcode), 32'h12);
    repeat (3) tick();
    fetch();
    check_output("basic.op2", 32'(bus.opcode), 32'h32);
    repeat (3) tick();
    fetch();
    check_output("basic.halt_op", 32'(bus.opcode), 32'h0);
    check_output("basic.halt_cnt", 32'(instr_count), 32'd3);
    check_output("basic.halt_pc", 32'(bus.pc), 32'd2);
    tick();
    check_output("basic.done", 32'(done), 32'd1);
    check_output("basic.busy", 32'(busy), 32'd0);
    check_all("basic.end");

    // Jump
    do_reset("jump");
    load_slot(4'd0, 6'b000001);
    load_slot(4'd5, 6'b111111);
    pulse_start();
    fetch();
    apply_stimulus(0, 1, 0, 2'b10, 0, 4'd5);
    tick();
    apply_stimulus(0, 0, 0, 2'd0, 0, 4'd0);
    check_output("jump.pc", 32'(bus.pc), 32'd5);
    fetch();
    check_output("jump.count", 32'(instr_count), 32'd2);
    tick();
    check_output("jump.done", 32'(done), 32'd1);
    check_all("jump.end");

    // Branch not taken, then taken
    do_reset("branch");
    load_slot(4'd0, 6'b100000);
    pulse_start();
    fetch();
    check_output("branch.op", 32'(bus.opcode), 32'h20);
    apply_stimulus(0, 0, 1, 2'b01, 0, 4'd7);
    tick();
    check_output("branch.nt_pc", 32'(bus.pc), 32'd1);
    apply_stimulus(0, 0, 1, 2'b01, 1, 4'd7);
    tick();
    apply_stimulus(0, 0, 0, 2'd0, 0, 4'd0);
    check_output("branch.t_pc", 32'(bus.pc), 32'd7);
    check_all("branch.end");

    // Fetch and jump on the same edge
    do_reset("same");
    load_slot(4'd0, 6'b010010);
    load_slot(4'd1, 6'b000100);
    pulse_start();
    fetch();
    apply_stimulus(1, 1, 0, 2'b10, 0, 4'd3);
    tick();
    apply_stimulus(0, 0, 0, 2'd0, 0, 4'd0);
    check_output("same.pc", 32'(bus.pc), 32'd3);
    check_output("same.op", 32'(bus.opcode), 32'h04);
    check_output("same.count", 32'(instr_count), 32'd2);

    // Wrap around all slots; a load during RUN must not land
    do_reset("wrap");
    for (int i = 0; i < 16; i++) load_slot(4'(i), 6'b010000);
    pulse_start();
    for (int k = 1; k <= 17; k++) begin
      if (k == 2) begin
        load_en = 1;
        load_addr = 4'd3;
        load_opcode = 6'b111111;
      end
      fetch();
      load_en = 0;
      check_output("wrap.pc", 32'(bus.pc), 32'(k % 16));
      check_output("wrap.op", 32'(bus.opcode), 32'h10);
      check_output("wrap.busy", 32'(busy), 32'd1);
    end
    check_output("wrap.count", 32'(instr_count), 32'd17);
    check_all("wrap.end");

    // Reset mid-run wipes the program
    do_reset("midrun");
    pulse_start();
    fetch();
    check_output("midrun.op", 32'(bus.opcode), 32'h0);
    check_output("midrun.busy", 32'(busy), 32'd1);
    check_all("midrun.end");

    // Randomized program and controller activity
    do_reset("rand");
    for (int i = 0; i < 16; i++)
      load_slot(4'(i), ($urandom_range(0, 7) == 0) ? 6'b111111 : 6'($urandom_range(0, 62)));
    for (int cyc = 0; cyc < 400; cyc++) begin
      apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      load_en = ($urandom_range(0, 9) == 0);
      load_addr = 4'($urandom_range(0, 15));
      load_opcode = 6'($urandom_range(0, 63));
      start = ($urandom_range(0, 15) == 0);
      tick();
      check_all("rand");
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/opcode_sequencer.md
# opcode_sequencer

Program-store and fetch responder that sits on the opcode side of the multicycle `controller`. It holds a small loadable program of 6-bit opcodes and answers the controller's fetch strobe (`IRWrite`) with the next opcode. It tracks a program counter that follows the controller's `PCWrite`/`PCWriteCond`/`PCSource` outputs. It is used as the instruction source for controller bring-up and for system-level sequencing tests.

## Interface
- `DEPTH`, 16: number of program slots.
- `AW`, 4: program-counter/address width; DEPTH = 2**AW.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write `load_opcode` into slot `load_addr`; honoured only in IDLE.
- `load_addr`  in  AW  program slot to write.
- `load_opcode`  in  6  opcode to store.
- `start`  in  1  begin execution from slot 0; honoured in IDLE or DONE.
- `IRWrite`  in  1  controller fetch strobe (state 0).
- `PCWrite`  in  1  controller unconditional PC write.
- `PCWriteCond`  in  1  controller conditional PC write (branch).
- `PCSource`  in  2  controller PC source select.
- `zero`  in  1  ALU zero flag qualifying `PCWriteCond`.
- `jump_target`  in  AW  target slot for jump/branch.
- `opcode`  out  6  current instruction opcode to the controller.
- `pc`  out  AW  slot of the next fetch.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `instr_count`  out  16  instructions fetched since the last `start`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE on a HALT fetch.
  - DONE -> RUN on `start`.
  - No other transitions.
- Program store: DEPTH x 6-bit registers.
  - A write occurs on the clock edge where `load_en`=1 and state=IDLE.
  - `load_en` is ignored in RUN and DONE.
- `start` (in IDLE or DONE):
  - `pc`<=0, `instr_count`<=0, `opcode`<=6'b000000.
  - A simultaneous `load_en` in IDLE still writes.
- Fetch, in RUN with `IRWrite`=1:
  - `opcode`<=prog[pc].
  - `pc`<=pc+1, modulo DEPTH: slot DEPTH-1 wraps to 0 and execution continues.
  - `instr_count`<=instr_count+1, saturating at 16'hFFFF.
- HALT: a fetch that reads 6'b111111.
  - `opcode`<=6'b000000 (NOP), `pc` holds, `instr_count` increments, state->DONE.
- Jump: in RUN, `PCWrite`=1 and `PCSource`=2'b10 -> `pc`<=`jump_target`.
- Branch: in RUN, `PCWriteCond`=1, `zero`=1 and `PCSource`=2'b01 -> `pc`<=`jump_target`.
  - With `zero`=0 there is no change.
- Priority when events coincide: jump/branch load of `pc` overrides the fetch increment. `opcode` and `instr_count` still update from the fetch.
- `PCWrite` with `PCSource`=2'b00 has no effect; the fetch increment is implicit.
- `IRWrite`, `PCWrite` and `PCWriteCond` are ignored outside RUN.
- `opcode` holds its value between fetches. It is 0 in IDLE and DONE.

## Timing
- Reset (asynchronous, `reset`=0):
  - state=IDLE, `opcode`=0, `pc`=0, `busy`=0, `done`=0, `instr_count`=0.
  - All program slots = 0 (NOP).
- Reset asserted mid-RUN aborts immediately with the same values, so the program must be reloaded.
- All outputs are registered. No combinational path from inputs to outputs.
- Fetch latency: `IRWrite` sampled high at edge N -> new `opcode` valid from edge N to edge N+1, i.e. during the controller's decode state 1.
- `busy` and `done` update on the edge that changes state. `done` rises on the edge after the HALT fetch edge.
- `start` held high for several cycles re-arms only once per IDLE/DONE visit. While in RUN it is ignored.

## Test plan
- Reset, then load slots 0..2 = 010010 (ADD), 110010 (ADDI), 111111, then pulse `start`.
  - Drive `IRWrite` every 4 cycles.
  - Required: `opcode` = 010010 then 110010.
  - At HALT: `opcode`=0 and `done`=1 one cycle after the third fetch; `instr_count`=3 and `pc`=2.
- Jump: slot 0 = 000001, slot 5 = 111111, `jump_target`=5.
  - After the fetch, pulse `PCWrite` with `PCSource`=10.
  - Required: `pc`=5, next fetch HALTs, `instr_count`=2.
- Branch: slot 0 = 100000.
  - `PCWriteCond`=1 with `PCSource`=01 and `zero`=0 -> `pc` stays 1.
  - Repeat with `zero`=1 and `jump_target`=7 -> `pc`=7.
- Same edge: `IRWrite`=1 and `PCWrite`=1 with `PCSource`=10 and `jump_target`=3.
  - Required: `pc`=3, `opcode`=prog[old pc], `instr_count` increments.
- Wrap: fill all slots with 010000 and fetch 17 times.
  - Required: `pc` goes 15 -> 0 -> 1, `busy` stays 1, `instr_count`=17.
  - Also: `load_en` during RUN leaves slot contents unchanged.
- Drop `reset` low mid-RUN between clock edges.
  - Required: outputs go to reset values immediately, before the next edge.
  - All slots read back as 0: start, then one fetch gives `opcode`=0.
